// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: segment codes,
// segment bit positions, bank geometry, handshake states and a helper used
// by the leading-zero blanking option.
package seg7_scan_ctrl_pkg;

  localparam int unsigned DIGITS_PER_BANK = 4;

  // Segment bit positions within a {DP,G,F,E,D,C,B,A} byte
  localparam int unsigned SEG_CODE_W = 7;
  localparam int unsigned SEG_DP     = 7;

  // Active-high {G,F,E,D,C,B,A} codes for hex digits
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Pending-buffer occupancy
  typedef enum logic {StEmpty, StFull} pend_state_e;

  // Index of the most significant nonzero nibble of a bank; 0 when all zero
  function automatic logic [1:0] msd_index(logic [15:0] half);
    logic [1:0] r;
    r = 2'd0;
    for (int d = 0; d < 4; d++) begin
      if (half[4*d +: 4] != 4'h0) r = 2'(d);
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment code decoder.
module hex_to_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0]            nibble_i,
  output logic [SEG_CODE_W-1:0] code_o
);

  // Full 16-entry lookup
  always_comb begin
    code_o = SEG_0;
    unique case (nibble_i)
      4'h0: code_o = SEG_0;
      4'h1: code_o = SEG_1;
      4'h2: code_o = SEG_2;
      4'h3: code_o = SEG_3;
      4'h4: code_o = SEG_4;
      4'h5: code_o = SEG_5;
      4'h6: code_o = SEG_6;
      4'h7: code_o = SEG_7;
      4'h8: code_o = SEG_8;
      4'h9: code_o = SEG_9;
      4'hA: code_o = SEG_A;
      4'hB: code_o = SEG_B;
      4'hC: code_o = SEG_C;
      4'hD: code_o = SEG_D;
      4'hE: code_o = SEG_E;
      4'hF: code_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for two 4-digit multiplexed 7-segment banks.
// A value accepted over valid/ready waits in a pending buffer and is copied
// into the displayed shadow only at a frame boundary, so a frame never tears.
// Optional build macro: SEG7_ZERO_BLANK_EN (blank leading zero digits per bank).
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] num_i,
  input  logic        num_valid_i,
  output logic        num_ready_o,
  input  logic [7:0]  dp_i,
  input  logic        en_i,
  output logic [7:0]  seg0_o,
  output logic [3:0]  an0_o,
  output logic [7:0]  seg1_o,
  output logic [3:0]  an1_o
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [1:0]    IDX_LAST  = 2'(DIGITS_PER_BANK - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick, frame_end, xfer, commit;
  pend_state_e   state_q, state_d;
  logic [31:0]   pend_q, shadow_q;
  logic [7:0]    pend_dp_q, dp_shadow_q;
  logic [7:0]    seg0_q, seg0_d, seg1_q, seg1_d;
  logic [3:0]    an0_q, an0_d, an1_q, an1_d;
  logic [3:0]    nib0, nib1;
  logic [6:0]    code0, code1;
  logic          lit0, lit1;

  // Slot timing: prescaler wraps every SCAN_DIV cycles, idx advances per slot
  always_comb begin
    tick        = (prescaler_q == PRE_LAST);
    frame_end   = tick && (idx_q == IDX_LAST);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
  end

  // Scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
    end
  end

  // Pending-buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Pending-buffer next state: fill on transfer, drain on frame boundary
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (xfer) state_d = StFull;
      StFull:  if (frame_end) state_d = StEmpty;
    endcase
  end

  // Handshake outputs; a value captured on a boundary waits for the next one
  always_comb begin
    num_ready_o = (state_q == StEmpty);
    xfer        = num_valid_i && num_ready_o;
    commit      = (state_q == StFull) && frame_end;
  end

  // Pending and shadow data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_dp_q   <= '0;
      shadow_q    <= '0;
      dp_shadow_q <= '0;
    end else begin
      if (xfer) begin
        pend_q    <= num_i;
        pend_dp_q <= dp_i;
      end
      if (commit) begin
        shadow_q    <= pend_q;
        dp_shadow_q <= pend_dp_q;
      end
    end
  end

  assign nib0 = shadow_q[{idx_q, 2'b00} +: 4];
  assign nib1 = shadow_q[{1'b1, idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec0 (
    .nibble_i (nib0),
    .code_o   (code0)
  );

  hex_to_seg7 u_dec1 (
    .nibble_i (nib1),
    .code_o   (code1)
  );

`ifdef SEG7_ZERO_BLANK_EN
  // Digit lit if at or below the top nonzero nibble, or its DP is set
  always_comb begin
    lit0 = (idx_q <= msd_index(shadow_q[15:0]))  || dp_shadow_q[{1'b0, idx_q}];
    lit1 = (idx_q <= msd_index(shadow_q[31:16])) || dp_shadow_q[{1'b1, idx_q}];
  end
`else
  assign lit0 = 1'b1;
  assign lit1 = 1'b1;
`endif

  // Next display outputs: blank gap holds segments, disable clears everything
  always_comb begin
    seg0_d = seg0_q;
    seg1_d = seg1_q;
    an0_d  = '0;
    an1_d  = '0;
    if (!en_i) begin
      seg0_d = '0;
      seg1_d = '0;
    end else if (prescaler_q >= PRE_BLANK) begin
      seg0_d = {dp_shadow_q[{1'b0, idx_q}], code0};
      seg1_d = {dp_shadow_q[{1'b1, idx_q}], code1};
      an0_d  = lit0 ? (4'b0001 << idx_q) : 4'b0000;
      an1_d  = lit1 ? (4'b0001 << idx_q) : 4'b0000;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg0_q <= '0;
      seg1_q <= '0;
      an0_q  <= '0;
      an1_q  <= '0;
    end else begin
      seg0_q <= seg0_d;
      seg1_q <= seg1_d;
      an0_q  <= an0_d;
      an1_q  <= an1_d;
    end
  end

  assign seg0_o = seg0_q;
  assign seg1_o = seg1_q;
  assign an0_o  = an0_q;
  assign an1_o  = an1_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a small scan/handshake model.
module tb_seg7_scan_ctrl;

  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] num_i;
  logic        num_valid_i;
  logic        num_ready_o;
  logic [7:0]  dp_i;
  logic        en_i;
  logic [7:0]  seg0_o, seg1_o;
  logic [3:0]  an0_o, an1_o;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .num_i       (num_i),
    .num_valid_i (num_valid_i),
    .num_ready_o (num_ready_o),
    .dp_i        (dp_i),
    .en_i        (en_i),
    .seg0_o      (seg0_o),
    .an0_o       (an0_o),
    .seg1_o      (seg1_o),
    .an1_o       (an1_o)
  );

  int checks   = 0;
  int failures = 0;

  // Model: cycle count since reset release, committed and buffered values
  int unsigned t;
  logic [31:0] m_shadow, m_pend;
  logic [7:0]  m_dp, m_pdp;
  bit          m_full;
  logic [7:0]  e_seg0, e_seg1;
  logic [3:0]  e_an0, e_an1;

  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [31:0] num;
    logic [7:0]  dp;
    logic [7:0]  s0;
    logic [7:0]  s1;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lit(input int bank, input int d);
`ifdef SEG7_ZERO_BLANK_EN
    int top = 0;
    for (int k = 0; k < 4; k++) begin
      if (m_shadow[16*bank + 4*k +: 4] != 4'h0) top = k;
    end
    return (d <= top) || m_dp[4*bank + d];
`else
    return 1'b1;
`endif
  endfunction

  task automatic reset_model();
    t = 0;
    m_shadow = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_full = 0;
    e_seg0 = '0; e_seg1 = '0; e_an0 = '0; e_an1 = '0;
  endtask

  // One clock: predict from current state and inputs, advance, compare
  task automatic cyc();
    int  p    = t % SD;
    int  i    = (t / SD) % 4;
    bit  bnd  = (p == SD - 1) && (i == 3);
    bit  xfer = num_valid_i && !m_full;
    if (!en_i) begin
      e_seg0 = '0; e_seg1 = '0; e_an0 = '0; e_an1 = '0;
    end else if (p < BC) begin
      e_an0 = '0; e_an1 = '0;
    end else begin
      e_seg0 = {m_dp[i],     codes[m_shadow[4*i +: 4]]};
      e_seg1 = {m_dp[4 + i], codes[m_shadow[16 + 4*i +: 4]]};
      e_an0  = lit(0, i) ? (4'b0001 << i) : 4'b0000;
      e_an1  = lit(1, i) ? (4'b0001 << i) : 4'b0000;
    end
    if (bnd && m_full) begin
      m_shadow = m_pend; m_dp = m_pdp; m_full = 0;
    end
    if (xfer) begin
      m_pend = num_i; m_pdp = dp_i; m_full = 1;
    end
    t++;
    @(posedge clk);
    #1;
    check("outputs", {7'd0, an0_o, seg0_o, an1_o, seg1_o, num_ready_o},
          {7'd0, e_an0, e_seg0, e_an1, e_seg1, !m_full});
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!num_ready_o && n < 200) begin
      cyc();
      n++;
    end
    check("ready_return", {31'd0, num_ready_o}, 32'd1);
  endtask

  task automatic send(input logic [31:0] v, input logic [7:0] d, input bit hold);
    num_i = v; dp_i = d; num_valid_i = 1'b1;
    cyc();
    check("ready_drop", {31'd0, num_ready_o}, 32'd0);
    if (!hold) num_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] acc0, acc1;

    vecs[0] = '{num: 32'h8765_4321, dp: 8'h01, s0: 8'h86, s1: 8'h6D};
    vecs[1] = '{num: 32'hA5A5_5A5A, dp: 8'h10, s0: 8'h77, s1: 8'hED};
    vecs[2] = '{num: 32'h0123_89C0, dp: 8'h00, s0: 8'h3F, s1: 8'h4F};
    vecs[3] = '{num: 32'hFEDC_BA98, dp: 8'h11, s0: 8'hFF, s1: 8'hB9};

    rst_n = 1'b0; en_i = 1'b1; num_valid_i = 1'b0; num_i = '0; dp_i = '0;
    reset_model();
    #8;
    check("reset_outputs", {7'd0, an0_o, seg0_o, an1_o, seg1_o, num_ready_o}, 32'd1);
    #9 rst_n = 1'b1;

    // Idle scan of zero
    for (int k = 0; k < 20; k++) cyc();

    // Table: commit each value, then check digit 0 of the new frame
    for (int v = 0; v < 4; v++) begin
      wait_ready(n);
      send(vecs[v].num, vecs[v].dp, v == 0);
      wait_ready(n);
      cyc();
      cyc();
      check("digit0_an0",  {28'd0, an0_o}, 32'd1);
      check("digit0_seg0", {24'd0, seg0_o}, {24'd0, vecs[v].s0});
      check("digit0_seg1", {24'd0, seg1_o}, {24'd0, vecs[v].s1});
      num_valid_i = 1'b0;
    end

    // Transfer on the frame-boundary cycle defers commit by a full frame
    wait_ready(n);
    n = 0;
    while (!((t % SD) == SD - 1 && ((t / SD) % 4) == 3) && n < 20) begin
      cyc();
      n++;
    end
    num_i = 32'hFFFF_FFFF; dp_i = 8'h00; num_valid_i = 1'b1;
    cyc();
    num_valid_i = 1'b0;
    wait_ready(n);
    check("deferred_commit_cycles", n, 32'd16);
    cyc();
    cyc();
    check("all_f_seg0", {24'd0, seg0_o}, 32'h71);
    check("all_f_seg1", {24'd0, seg1_o}, 32'h71);

    // Display disable mid-slot
    cyc();
    en_i = 1'b0;
    cyc();
    check("disable_an0",  {28'd0, an0_o},  32'd0);
    check("disable_seg1", {24'd0, seg1_o}, 32'd0);
    for (int k = 0; k < 5; k++) cyc();
    en_i = 1'b1;
    for (int k = 0; k < 12; k++) cyc();

    // Leading-zero value: digits lit over a whole frame
    wait_ready(n);
    send(32'h0000_0120, 8'h00, 0);
    wait_ready(n);
    acc0 = '0; acc1 = '0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      acc0 |= an0_o;
      acc1 |= an1_o;
    end
`ifdef SEG7_ZERO_BLANK_EN
    check("zb_bank0_lit", {28'd0, acc0}, 32'h7);
    check("zb_bank1_lit", {28'd0, acc1}, 32'h1);
`else
    check("zb_bank0_lit", {28'd0, acc0}, 32'hF);
    check("zb_bank1_lit", {28'd0, acc1}, 32'hF);
`endif

    // Async reset while pending is full: pending value must be lost
    wait_ready(n);
    send(32'hDEAD_BEEF, 8'hFF, 0);
    for (int k = 0; k < 3; k++) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {7'd0, an0_o, seg0_o, an1_o, seg1_o, num_ready_o}, 32'd1);
    reset_model();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) cyc();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      num_valid_i = ($urandom_range(0, 3) == 0);
      num_i       = $urandom;
      dp_i        = 8'($urandom);
      en_i        = ($urandom_range(0, 15) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
